cnn_stream_sequencer: RTL and testbench



---
 rtl/cnn_stream_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cnn_stream_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_stream_sequencer.sv
// CNN image-pass sequencer: fetches pixels over OBI, feeds the line buffer,
// writes back each relu result and reports completion / count errors.
module cnn_stream_sequencer #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] input_base_i,
  input  logic [ADDR_WIDTH-1:0] output_base_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [DATA_WIDTH-1:0] pixel_o,
  output logic                  pixel_valid_o,
  input  logic                  window_valid_i,
  input  logic [RES_WIDTH-1:0]  result_i
);

  localparam int CW = $clog2(IMG_W*IMG_H+1);
  localparam logic [CW-1:0] NPIX = CW'(IMG_W*IMG_H);
  localparam logic [CW-1:0] NOUT = CW'((IMG_W-2)*(IMG_H-2));

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_RSP, PUSH,
    CHECK, WR_REQ, WR_RSP, FIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
  logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
  logic [CW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic [31:0]           res_ext;
  logic                  pix_last;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  unused_rdata;

  assign unused_rdata = ^mem_rdata_i;
  assign pix_last = (pix_cnt_q == NPIX);
  assign rd_addr  = in_base_q + (ADDR_WIDTH'(pix_cnt_q) << 2);
  assign wr_addr  = out_base_q + (ADDR_WIDTH'(out_cnt_q) << 2);

  always_comb begin
    res_ext = '0;
    res_ext[RES_WIDTH-1:0] = result_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      in_base_q  <= '0;
      out_base_q <= '0;
      pix_cnt_q  <= '0;
      out_cnt_q  <= '0;
      pixel_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      pix_cnt_q  <= pix_cnt_d;
      out_cnt_q  <= out_cnt_d;
      pixel_q    <= pixel_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    pix_cnt_d  = pix_cnt_q;
    out_cnt_d  = out_cnt_q;
    pixel_d    = pixel_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          in_base_d  = input_base_i;
          out_base_d = output_base_i;
          pix_cnt_d  = '0;
          out_cnt_d  = '0;
          err_d      = 1'b0;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_gnt_i) state_d = RD_RSP;
      end
      RD_RSP: begin
        if (mem_rvalid_i) begin
          pixel_d = mem_rdata_i[DATA_WIDTH-1:0];
          state_d = PUSH;
        end
      end
      PUSH: begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        state_d   = CHECK;
      end
      CHECK: begin
        if (window_valid_i) begin
          wdata_d = res_ext;
          state_d = WR_REQ;
        end else begin
          state_d = pix_last ? FIN : RD_REQ;
        end
      end
      WR_REQ: begin
        if (mem_gnt_i) state_d = WR_RSP;
      end
      WR_RSP: begin
        if (mem_rvalid_i) begin
          out_cnt_d = out_cnt_q + 1'b1;
          state_d   = pix_last ? FIN : RD_REQ;
        end
      end
      FIN: begin
        err_d   = err_q | (out_cnt_q != NOUT);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != IDLE);
    done_o        = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    pixel_valid_o = 1'b0;
    unique case (state_q)
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = rd_addr;
      end
      WR_REQ: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = wr_addr;
      end
      PUSH:    pixel_valid_o = 1'b1;
      FIN:     done_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_be_o    = 4'hF;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;
  assign pixel_o     = pixel_q;

endmodule

// File: tb/tb_cnn_stream_sequencer.sv
// Bench: 4x4 pass with OBI responder and line-buffer model,
// plus a 3x3 RES_WIDTH=16 instance for result zero-extension.
module tb_cnn_stream_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_base = 32'h0;
  logic [31:0] out_base = 32'h0;
  logic        busy, done, err;
  logic        req, gnt, we, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [7:0]  pixel;
  logic        pv;
  logic        wv = 1'b0;
  logic [31:0] result;

  cnn_stream_sequencer #(
    .IMG_W(4), .IMG_H(4), .DATA_WIDTH(8),
    .RES_WIDTH(32), .ADDR_WIDTH(32)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .input_base_i(in_base), .output_base_i(out_base),
    .busy_o(busy), .done_o(done), .err_o(err),
    .mem_req_o(req), .mem_gnt_i(gnt),
    .mem_addr_o(addr), .mem_we_o(we), .mem_be_o(be),
    .mem_wdata_o(wdata), .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata), .pixel_o(pixel),
    .pixel_valid_o(pv), .window_valid_i(wv),
    .result_i(result)
  );

  logic        start_b = 1'b0;
  logic        busy_b, done_b, err_b;
  logic        req_b, we_b;
  logic        rv_b = 1'b0;
  logic        wv_b = 1'b0;
  logic [31:0] addr_b, wdata_b;
  logic [3:0]  be_b;
  logic [7:0]  pixel_b;
  logic        pv_b;
  logic [31:0] res32 = 32'h8000_0001;
  logic [15:0] result_b;
  int          pbcnt = 0;

  assign result_b = res32[15:0];

  cnn_stream_sequencer #(
    .IMG_W(3), .IMG_H(3), .DATA_WIDTH(8),
    .RES_WIDTH(16), .ADDR_WIDTH(32)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .input_base_i(32'h0000_0100),
    .output_base_i(32'h0000_3000),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
    .mem_req_o(req_b), .mem_gnt_i(req_b),
    .mem_addr_o(addr_b), .mem_we_o(we_b), .mem_be_o(be_b),
    .mem_wdata_o(wdata_b), .mem_rvalid_i(rv_b),
    .mem_rdata_i(32'h0), .pixel_o(pixel_b),
    .pixel_valid_o(pv_b), .window_valid_i(wv_b),
    .result_i(result_b)
  );

  // OBI responder with random grant/response latency up to maxd
  int          maxd = 0;
  logic        hold_wr = 1'b0;
  logic [15:0] wmask = 16'h0;
  int          gwait = 0;
  int          rwait = 0;
  logic        pend = 1'b0;
  logic [31:0] raddr = 32'h0;

  assign gnt = req && (gwait == 0) && !(hold_wr && we);
  assign rvalid = pend && (rwait == 0);
  assign rdata = {24'hA5A5A5, raddr[9:2]};
  assign result = {24'hC0DE00, pixel};

  always @(posedge clk) begin
    if (req && !gnt && gwait > 0) gwait <= gwait - 1;
    if (req && gnt) begin
      pend  <= 1'b1;
      raddr <= addr;
      rwait <= int'($urandom_range(0, maxd));
      gwait <= int'($urandom_range(0, maxd));
    end else if (pend) begin
      if (rwait == 0) pend <= 1'b0;
      else rwait <= rwait - 1;
    end
    wv    <= pv && wmask[pixel[3:0]];
    rv_b  <= req_b;
    wv_b  <= pv_b && (pbcnt == 8);
    pbcnt <= pbcnt + (pv_b ? 1 : 0);
  end

  logic [31:0] ra_q[$], wa_q[$], wd_q[$], px_q[$];
  logic [31:0] wdb_q[$], wab_q[$];
  int          done_n = 0;
  int          stab_err = 0;
  logic        held = 1'b0;
  logic        h_we = 1'b0;
  logic [31:0] h_addr = 32'h0;
  logic [31:0] h_wd = 32'h0;

  always @(negedge clk) begin
    if (req && gnt) begin
      if (we) begin
        wa_q.push_back(addr);
        wd_q.push_back(wdata);
      end else begin
        ra_q.push_back(addr);
      end
    end
    if (pv) px_q.push_back({24'h0, pixel});
    if (done) done_n <= done_n + 1;
    if (held && req) begin
      if (addr != h_addr || we != h_we ||
          (we && wdata != h_wd))
        stab_err <= stab_err + 1;
    end
    held   <= req && !gnt;
    h_addr <= addr;
    h_we   <= we;
    h_wd   <= wdata;
    if (req_b && we_b) begin
      wab_q.push_back(addr_b);
      wdb_q.push_back(wdata_b);
    end
  end

  int tests = 0;
  int failed = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic run_pass(input int md,
                          input logic [15:0] mask,
                          input bit restart,
                          input bit exp_err,
                          input int exp_nwr);
    int r0, w0, p0, d0, s0, k;
    bit got;
    r0 = ra_q.size();
    w0 = wa_q.size();
    p0 = px_q.size();
    d0 = done_n;
    s0 = stab_err;
    maxd = md;
    wmask = mask;
    @(negedge clk);
    in_base = 32'h1000;
    out_base = 32'h2000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_base = 32'hDEAD_0000;
    out_base = 32'hBEEF_0000;
    check("busy_after_start", {31'h0, busy}, 1);
    check("err_cleared", {31'h0, err}, 0);
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      start = restart && (c == 30);
    end
    start = 1'b0;
    check("done_seen", {31'h0, got}, 1);
    @(negedge clk);
    check("busy_after_fin", {31'h0, busy}, 0);
    check("done_one_cycle", {31'h0, done}, 0);
    repeat (10) @(negedge clk);
    check("done_count", done_n - d0, 1);
    check("err", {31'h0, err}, {31'h0, exp_err});
    check("n_reads", ra_q.size() - r0, 16);
    check("n_pixels", px_q.size() - p0, 16);
    for (int i = 0; i < 16; i++) begin
      if (r0 + i < ra_q.size())
        check("rd_addr", ra_q[r0+i], 32'h1000 + 4*i);
      if (p0 + i < px_q.size())
        check("pixel", px_q[p0+i], i);
    end
    check("n_writes", wa_q.size() - w0, exp_nwr);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        if (w0 + k < wa_q.size()) begin
          check("wr_addr", wa_q[w0+k], 32'h2000 + 4*k);
          check("wr_data", wd_q[w0+k], 32'hC0DE_0000 | i);
        end
        k++;
      end
    end
    check("stable_while_wait", stab_err - s0, 0);
  endtask

  typedef struct {
    int          md;
    logic [15:0] mask;
    bit          restart;
    bit          exp_err;
    int          exp_nwr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{0, 16'hCC00, 1'b0, 1'b0, 4};
    tbl[1] = '{5, 16'hCC00, 1'b0, 1'b0, 4};
    tbl[2] = '{3, 16'h4C00, 1'b0, 1'b1, 3};
    tbl[3] = '{0, 16'hCC00, 1'b1, 1'b0, 4};
    tbl[4] = '{4, 16'hCC00, 1'b1, 1'b0, 4};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_err", {31'h0, err}, 0);
    check("rst_req", {31'h0, req}, 0);
    check("rst_we", {31'h0, we}, 0);
    check("rst_pv", {31'h0, pv}, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_pixel", {24'h0, pixel}, 0);
    check("rst_be", {28'h0, be}, 32'hF);
    check("rst_b_be", {28'h0, be_b}, 32'hF);
    check("rst_b_pixel", {24'h0, pixel_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_pass(tbl[i].md, tbl[i].mask, tbl[i].restart,
               tbl[i].exp_err, tbl[i].exp_nwr);
      repeat (5) @(negedge clk);
      check("err_sticky", {31'h0, err},
            {31'h0, tbl[i].exp_err});
    end

    // abort while a write request waits for grant
    begin
      bit found;
      maxd = 0;
      wmask = 16'hCC00;
      hold_wr = 1'b1;
      in_base = 32'h1000;
      out_base = 32'h2000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
        @(negedge clk);
        if (req && we) found = 1'b1;
      end
      check("wr_req_reached", {31'h0, found}, 1);
      repeat (3) @(negedge clk);
      check("wr_req_held", {31'h0, req}, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_req", {31'h0, req}, 0);
      check("abort_busy", {31'h0, busy}, 0);
      check("abort_we", {31'h0, we}, 0);
      @(negedge clk);
      rst = 1'b0;
      hold_wr = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_abort", {31'h0, busy}, 0);
      run_pass(0, 16'hCC00, 1'b0, 1'b0, 4);
    end

    // RES_WIDTH=16 instance: single window, low half only
    begin
      bit got;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 1000 && !got; c++) begin
        @(negedge clk);
        if (done_b) got = 1'b1;
      end
      check("b_done", {31'h0, got}, 1);
      @(negedge clk);
      check("b_err", {31'h0, err_b}, 0);
      check("b_busy", {31'h0, busy_b}, 0);
      check("b_n_writes", wdb_q.size(), 1);
      if (wdb_q.size() > 0) begin
        check("b_wdata_zext", wdb_q[0], 32'h0000_0001);
        check("b_waddr", wab_q[0], 32'h0000_3000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
